// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retire, RS/LSB result capture, mispredict flush.
// Optional macro ROB_BYPASS_EN forwards same-cycle broadcasts onto the query ports.
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 allocValid,
    input  logic [1:0]           allocType,
    input  logic [4:0]           allocDestReg,
    input  logic                 allocPredTaken,
    input  logic [31:0]          allocAltPc,
    output logic [ROB_WIDTH-1:0] allocRobIndex,
    output logic                 full,
    input  logic                 rsUpdate,
    input  logic [ROB_WIDTH-1:0] rsRobIndex,
    input  logic [31:0]          rsUpdateVal,
    input  logic                 lsbUpdate,
    input  logic [ROB_WIDTH-1:0] lsbRobIndex,
    input  logic [31:0]          lsbUpdateVal,
    input  logic [ROB_WIDTH-1:0] query1Index,
    input  logic [ROB_WIDTH-1:0] query2Index,
    output logic                 query1Ready,
    output logic                 query2Ready,
    output logic [31:0]          query1Val,
    output logic [31:0]          query2Val,
    output logic                 commitValid,
    output logic [ROB_WIDTH-1:0] commitRobIndex,
    output logic [1:0]           commitType,
    output logic [4:0]           commitDestReg,
    output logic [31:0]          commitVal,
    output logic                 storeCommit,
    output logic                 flush,
    output logic [31:0]          flushPc
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] C_DEPTH    = (ROB_WIDTH+1)'(DEPTH);
    localparam logic [ROB_WIDTH:0] C_DEPTH_M1 = (ROB_WIDTH+1)'(DEPTH - 1);
    localparam logic [1:0] TYPE_STORE  = 2'b01;
    localparam logic [1:0] TYPE_BRANCH = 2'b10;
    localparam logic [1:0] TYPE_NOP    = 2'b11;

    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_ready;
    logic [DEPTH-1:0]     r_pred;
    logic [1:0]           r_type  [DEPTH];
    logic [4:0]           r_dest  [DEPTH];
    logic [31:0]          r_alt   [DEPTH];
    logic [31:0]          r_value [DEPTH];
    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_count;

    logic                 w_commit;
    logic                 w_mispredict;
    logic                 w_alloc_ok;
    logic                 w_rs_ok;
    logic                 w_lsb_ok;
    logic [ROB_WIDTH:0]   w_count_next;

    assign w_commit     = r_valid[r_head] & r_ready[r_head];
    assign w_mispredict = w_commit & (r_type[r_head] == TYPE_BRANCH)
                          & (r_value[r_head][0] != r_pred[r_head]);
    assign w_alloc_ok   = allocValid & (r_count != C_DEPTH) & ~w_mispredict;
    // RS result is dropped when the LSB targets the same entry in the same cycle
    assign w_rs_ok      = rsUpdate & r_valid[rsRobIndex] & ~w_mispredict
                          & ~(lsbUpdate & (lsbRobIndex == rsRobIndex));
    assign w_lsb_ok     = lsbUpdate & r_valid[lsbRobIndex] & ~w_mispredict;

    assign allocRobIndex = r_tail;
    assign full          = (r_count >= C_DEPTH_M1);

    // Occupancy after this cycle's alloc and retire
    always_comb begin
        w_count_next = r_count;
        case ({w_alloc_ok, w_commit})
            2'b10:   w_count_next = r_count + (ROB_WIDTH+1)'(1);
            2'b01:   w_count_next = r_count - (ROB_WIDTH+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Entry storage: allocation, result capture, retire and flush
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            r_valid <= '0;
            r_ready <= '0;
            r_pred  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_type[i]  <= 2'b00;
                r_dest[i]  <= 5'd0;
                r_alt[i]   <= 32'h0;
                r_value[i] <= 32'h0;
            end
        end else if (w_mispredict) begin
            r_valid <= '0;
        end else begin
            if (w_rs_ok) begin
                r_value[rsRobIndex] <= rsUpdateVal;
                r_ready[rsRobIndex] <= 1'b1;
            end
            if (w_lsb_ok) begin
                r_value[lsbRobIndex] <= lsbUpdateVal;
                r_ready[lsbRobIndex] <= 1'b1;
            end
            if (w_alloc_ok) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= (allocType == TYPE_NOP);
                r_type[r_tail]  <= allocType;
                r_dest[r_tail]  <= allocDestReg;
                r_pred[r_tail]  <= allocPredTaken;
                r_alt[r_tail]   <= allocAltPc;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
            end
        end
    end

    // Head/tail pointers and occupancy count
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_mispredict) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc_ok) begin
                r_tail <= r_tail + ROB_WIDTH'(1);
            end
            if (w_commit) begin
                r_head <= r_head + ROB_WIDTH'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Registered retire and redirect pulses
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            commitValid    <= 1'b0;
            commitRobIndex <= '0;
            commitType     <= 2'b00;
            commitDestReg  <= 5'd0;
            commitVal      <= 32'h0;
            storeCommit    <= 1'b0;
            flush          <= 1'b0;
            flushPc        <= 32'h0;
        end else begin
            commitValid <= w_commit;
            storeCommit <= w_commit & (r_type[r_head] == TYPE_STORE);
            flush       <= w_mispredict;
            if (w_commit) begin
                commitRobIndex <= r_head;
                commitType     <= r_type[r_head];
                commitDestReg  <= r_dest[r_head];
                commitVal      <= r_value[r_head];
            end
            if (w_mispredict) begin
                flushPc <= r_alt[r_head];
            end
        end
    end

    logic w_q1_stored;
    logic w_q2_stored;
    assign w_q1_stored = r_valid[query1Index] & r_ready[query1Index];
    assign w_q2_stored = r_valid[query2Index] & r_ready[query2Index];

`ifdef ROB_BYPASS_EN
    logic w_q1_lsb, w_q1_rs, w_q2_lsb, w_q2_rs;
    assign w_q1_lsb = lsbUpdate & (lsbRobIndex == query1Index) & r_valid[query1Index];
    assign w_q1_rs  = rsUpdate  & (rsRobIndex  == query1Index) & r_valid[query1Index];
    assign w_q2_lsb = lsbUpdate & (lsbRobIndex == query2Index) & r_valid[query2Index];
    assign w_q2_rs  = rsUpdate  & (rsRobIndex  == query2Index) & r_valid[query2Index];

    assign query1Ready = w_q1_lsb | w_q1_rs | w_q1_stored;
    assign query2Ready = w_q2_lsb | w_q2_rs | w_q2_stored;
    assign query1Val   = w_q1_lsb ? lsbUpdateVal : w_q1_rs ? rsUpdateVal
                       : w_q1_stored ? r_value[query1Index] : 32'h0;
    assign query2Val   = w_q2_lsb ? lsbUpdateVal : w_q2_rs ? rsUpdateVal
                       : w_q2_stored ? r_value[query2Index] : 32'h0;
`else
    assign query1Ready = w_q1_stored;
    assign query2Ready = w_q2_stored;
    assign query1Val   = w_q1_stored ? r_value[query1Index] : 32'h0;
    assign query2Val   = w_q2_stored ? r_value[query2Index] : 32'h0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (default ROB_WIDTH=4).
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        allocValid = 1'b0;
    logic [1:0]  allocType = 2'b00;
    logic [4:0]  allocDestReg = 5'd0;
    logic        allocPredTaken = 1'b0;
    logic [31:0] allocAltPc = 32'h0;
    logic [3:0]  allocRobIndex;
    logic        full;
    logic        rsUpdate = 1'b0;
    logic [3:0]  rsRobIndex = 4'd0;
    logic [31:0] rsUpdateVal = 32'h0;
    logic        lsbUpdate = 1'b0;
    logic [3:0]  lsbRobIndex = 4'd0;
    logic [31:0] lsbUpdateVal = 32'h0;
    logic [3:0]  query1Index = 4'd0;
    logic [3:0]  query2Index = 4'd0;
    logic        query1Ready, query2Ready;
    logic [31:0] query1Val, query2Val;
    logic        commitValid;
    logic [3:0]  commitRobIndex;
    logic [1:0]  commitType;
    logic [4:0]  commitDestReg;
    logic [31:0] commitVal;
    logic        storeCommit;
    logic        flush;
    logic [31:0] flushPc;

    int passed = 0;
    int total  = 0;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn(clk), .resetIn(rst_n),
        .allocValid(allocValid), .allocType(allocType), .allocDestReg(allocDestReg),
        .allocPredTaken(allocPredTaken), .allocAltPc(allocAltPc),
        .allocRobIndex(allocRobIndex), .full(full),
        .rsUpdate(rsUpdate), .rsRobIndex(rsRobIndex), .rsUpdateVal(rsUpdateVal),
        .lsbUpdate(lsbUpdate), .lsbRobIndex(lsbRobIndex), .lsbUpdateVal(lsbUpdateVal),
        .query1Index(query1Index), .query2Index(query2Index),
        .query1Ready(query1Ready), .query2Ready(query2Ready),
        .query1Val(query1Val), .query2Val(query2Val),
        .commitValid(commitValid), .commitRobIndex(commitRobIndex),
        .commitType(commitType), .commitDestReg(commitDestReg),
        .commitVal(commitVal), .storeCommit(storeCommit),
        .flush(flush), .flushPc(flushPc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [1:0] t, input logic [4:0] d,
                            input logic p, input logic [31:0] alt);
        allocValid = 1'b1; allocType = t; allocDestReg = d;
        allocPredTaken = p; allocAltPc = alt;
        tick();
        allocValid = 1'b0;
    endtask

    task automatic clr_upd();
        rsUpdate = 1'b0;
        lsbUpdate = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_commitValid", 32'(commitValid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_storeCommit", 32'(storeCommit), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_allocIdx", 32'(allocRobIndex), 32'd0);
        chk("rst_flushPc", flushPc, 32'd0);
        rst_n = 1'b1;
        tick();

        // basic REG commit
        do_alloc(2'b00, 5'd5, 1'b0, 32'h0);
        chk("t2_allocIdx", 32'(allocRobIndex), 32'd1);
        rsUpdate = 1'b1; rsRobIndex = 4'd0; rsUpdateVal = 32'h1234;
        tick();
        clr_upd();
        chk("t2_noCommitYet", 32'(commitValid), 32'd0);
        tick();
        chk("t2_commitValid", 32'(commitValid), 32'd1);
        chk("t2_commitIdx", 32'(commitRobIndex), 32'd0);
        chk("t2_commitDest", 32'(commitDestReg), 32'd5);
        chk("t2_commitVal", commitVal, 32'h1234);
        chk("t2_commitType", 32'(commitType), 32'd0);
        chk("t2_storeCommit", 32'(storeCommit), 32'd0);
        tick();
        chk("t2_pulseEnds", 32'(commitValid), 32'd0);

        // STORE retire raises storeCommit
        do_alloc(2'b01, 5'd0, 1'b0, 32'h0);
        lsbUpdate = 1'b1; lsbRobIndex = 4'd1; lsbUpdateVal = 32'h77;
        tick();
        clr_upd();
        tick();
        chk("st_commitValid", 32'(commitValid), 32'd1);
        chk("st_storeCommit", 32'(storeCommit), 32'd1);
        chk("st_commitIdx", 32'(commitRobIndex), 32'd1);
        chk("st_commitVal", commitVal, 32'h77);
        tick();
        chk("st_storeEnds", 32'(storeCommit), 32'd0);

        // out-of-order completion, queries and bypass
        do_alloc(2'b00, 5'd10, 1'b0, 32'h0);
        do_alloc(2'b00, 5'd11, 1'b0, 32'h0);
        do_alloc(2'b00, 5'd12, 1'b0, 32'h0);
        chk("t4_allocIdx", 32'(allocRobIndex), 32'd5);
        query1Index = 4'd3; query2Index = 4'd4;
        #1;
        chk("q1_notReady", 32'(query1Ready), 32'd0);
        chk("q1_valZero", query1Val, 32'd0);
        lsbUpdate = 1'b1; lsbRobIndex = 4'd3; lsbUpdateVal = 32'hAB;
        rsUpdate = 1'b1; rsRobIndex = 4'd4; rsUpdateVal = 32'h44;
        #1;
`ifdef ROB_BYPASS_EN
        chk("q1_bypReady", 32'(query1Ready), 32'd1);
        chk("q1_bypVal", query1Val, 32'hAB);
        chk("q2_bypReady", 32'(query2Ready), 32'd1);
        chk("q2_bypVal", query2Val, 32'h44);
`else
        chk("q1_noBypReady", 32'(query1Ready), 32'd0);
        chk("q1_noBypVal", query1Val, 32'd0);
        chk("q2_noBypReady", 32'(query2Ready), 32'd0);
        chk("q2_noBypVal", query2Val, 32'd0);
`endif
        tick();
        clr_upd();
        #1;
        chk("q1_storedReady", 32'(query1Ready), 32'd1);
        chk("q1_storedVal", query1Val, 32'hAB);
        chk("q2_storedReady", 32'(query2Ready), 32'd1);
        chk("q2_storedVal", query2Val, 32'h44);
        chk("t4_headBlocks", 32'(commitValid), 32'd0);
        rsUpdate = 1'b1; rsRobIndex = 4'd2; rsUpdateVal = 32'h22;
        tick();
        clr_upd();
        chk("t4_noCommitYet", 32'(commitValid), 32'd0);
        tick();
        chk("t4_c0_valid", 32'(commitValid), 32'd1);
        chk("t4_c0_idx", 32'(commitRobIndex), 32'd2);
        chk("t4_c0_dest", 32'(commitDestReg), 32'd10);
        chk("t4_c0_val", commitVal, 32'h22);
        tick();
        chk("t4_c1_valid", 32'(commitValid), 32'd1);
        chk("t4_c1_idx", 32'(commitRobIndex), 32'd3);
        chk("t4_c1_val", commitVal, 32'hAB);
        tick();
        chk("t4_c2_valid", 32'(commitValid), 32'd1);
        chk("t4_c2_dest", 32'(commitDestReg), 32'd12);
        chk("t4_c2_val", commitVal, 32'h44);
        tick();
        chk("t4_drained", 32'(commitValid), 32'd0);

        // NOP is ready at allocation
        do_alloc(2'b11, 5'd0, 1'b0, 32'h0);
        tick();
        chk("nop_commitValid", 32'(commitValid), 32'd1);
        chk("nop_commitType", 32'(commitType), 32'd3);
        chk("nop_commitIdx", 32'(commitRobIndex), 32'd5);
        tick();

        // mispredicted branch flushes younger REG and a same-cycle alloc
        do_alloc(2'b10, 5'd0, 1'b0, 32'h80);
        do_alloc(2'b00, 5'd3, 1'b0, 32'h0);
        chk("t5_allocIdx", 32'(allocRobIndex), 32'd8);
        rsUpdate = 1'b1; rsRobIndex = 4'd6; rsUpdateVal = 32'h1;
        lsbUpdate = 1'b1; lsbRobIndex = 4'd7; lsbUpdateVal = 32'h66;
        tick();
        clr_upd();
        chk("t5_noCommitYet", 32'(commitValid), 32'd0);
        allocValid = 1'b1; allocType = 2'b00; allocDestReg = 5'd9;
        tick();
        allocValid = 1'b0;
        chk("t5_flush", 32'(flush), 32'd1);
        chk("t5_flushPc", flushPc, 32'h80);
        chk("t5_commitValid", 32'(commitValid), 32'd1);
        chk("t5_commitType", 32'(commitType), 32'd2);
        chk("t5_commitIdx", 32'(commitRobIndex), 32'd6);
        chk("t5_allocIdxZero", 32'(allocRobIndex), 32'd0);
        chk("t5_full", 32'(full), 32'd0);
        tick();
        chk("t5_flushEnds", 32'(flush), 32'd0);
        chk("t5_regNoCommit", 32'(commitValid), 32'd0);
        chk("t5_allocIdxStill0", 32'(allocRobIndex), 32'd0);
        tick();
        chk("t5_regNoCommit2", 32'(commitValid), 32'd0);

        // correct branch, then RS/LSB collision on one index (LSB wins)
        do_alloc(2'b10, 5'd0, 1'b1, 32'h200);
        do_alloc(2'b00, 5'd7, 1'b0, 32'h0);
        rsUpdate = 1'b1; rsRobIndex = 4'd0; rsUpdateVal = 32'h1;
        tick();
        clr_upd();
        rsUpdate = 1'b1; rsRobIndex = 4'd1; rsUpdateVal = 32'h1;
        lsbUpdate = 1'b1; lsbRobIndex = 4'd1; lsbUpdateVal = 32'h2;
        tick();
        clr_upd();
        chk("br_ok_commit", 32'(commitValid), 32'd1);
        chk("br_ok_noFlush", 32'(flush), 32'd0);
        chk("br_ok_type", 32'(commitType), 32'd2);
        tick();
        chk("lsbwin_valid", 32'(commitValid), 32'd1);
        chk("lsbwin_idx", 32'(commitRobIndex), 32'd1);
        chk("lsbwin_val", commitVal, 32'h2);
        chk("lsbwin_dest", 32'(commitDestReg), 32'd7);

        // asynchronous reset mid-run with five entries outstanding
        for (int i = 0; i < 5; i++) do_alloc(2'b00, 5'd1, 1'b0, 32'h0);
        chk("t1_allocIdxPre", 32'(allocRobIndex), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_allocIdx", 32'(allocRobIndex), 32'd0);
        chk("t1_commitVal", commitVal, 32'd0);
        chk("t1_commitDest", 32'(commitDestReg), 32'd0);
        chk("t1_commitIdx", 32'(commitRobIndex), 32'd0);
        chk("t1_commitType", 32'(commitType), 32'd0);
        chk("t1_commitValid", 32'(commitValid), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("t1_relAllocIdx", 32'(allocRobIndex), 32'd0);
        chk("t1_relFull", 32'(full), 32'd0);

        // fill to full, wrap, and an ignored overflow alloc
        for (int i = 0; i < 14; i++) do_alloc(2'b00, 5'd2, 1'b0, 32'h0);
        chk("t3_full14", 32'(full), 32'd0);
        chk("t3_idx14", 32'(allocRobIndex), 32'd14);
        do_alloc(2'b00, 5'd2, 1'b0, 32'h0);
        chk("t3_full15", 32'(full), 32'd1);
        chk("t3_idx15", 32'(allocRobIndex), 32'd15);
        do_alloc(2'b00, 5'd2, 1'b0, 32'h0);
        chk("t3_wrapIdx", 32'(allocRobIndex), 32'd0);
        chk("t3_full16", 32'(full), 32'd1);
        do_alloc(2'b11, 5'd2, 1'b0, 32'h0);
        chk("t3_ignoredIdx", 32'(allocRobIndex), 32'd0);
        chk("t3_ignoredFull", 32'(full), 32'd1);
        chk("t3_noCommit", 32'(commitValid), 32'd0);
        rsUpdate = 1'b1; rsRobIndex = 4'd0; rsUpdateVal = 32'h5A;
        tick();
        clr_upd();
        tick();
        chk("t3_commitValid", 32'(commitValid), 32'd1);
        chk("t3_commitIdx", 32'(commitRobIndex), 32'd0);
        chk("t3_commitVal", commitVal, 32'h5A);
        chk("t3_fullAt15", 32'(full), 32'd1);
        tick();
        chk("t3_nextNotReady", 32'(commitValid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer downstream of the reservation station and load/store buffer. It allocates ROB indices at issue and captures result broadcasts from the RS ALU and the LSB. It retires entries in program order, one per cycle, and raises a flush when a committed branch was mispredicted. It also provides two combinational operand-query ports for the issue stage.

Parameters:
ROB_WIDTH, 4, index width; depth DEPTH = 2**ROB_WIDTH entries

Ports:
clockIn  input  1  clock
resetIn  input  1  asynchronous, active-low reset
allocValid  input  1  allocate one entry at tail this cycle
allocType  input  2  00 REG, 01 STORE, 10 BRANCH, 11 NOP
allocDestReg  input  5  destination register (REG only)
allocPredTaken  input  1  predicted direction (BRANCH only)
allocAltPc  input  32  PC to redirect to if the branch was mispredicted
allocRobIndex  output  ROB_WIDTH  index the next allocation receives (current tail)
full  output  1  count >= DEPTH-1
rsUpdate / rsRobIndex / rsUpdateVal  input  1/ROB_WIDTH/32  RS ALU broadcast
lsbUpdate / lsbRobIndex / lsbUpdateVal  input  1/ROB_WIDTH/32  LSB broadcast
query1Index, query2Index  input  ROB_WIDTH  operand lookup index
query1Ready, query2Ready  output  1  entry holds a result
query1Val, query2Val  output  32  result value
commitValid  output  1  registered one-cycle retire pulse
commitRobIndex  output  ROB_WIDTH  retired index
commitType  output  2  retired type
commitDestReg  output  5  retired destination
commitVal  output  32  retired value
storeCommit  output  1  pulse: head STORE retired; LSB may write memory
flush  output  1  registered one-cycle mispredict pulse
flushPc  output  32  redirect PC, valid with flush

Behaviour:
- Reset (resetIn=0, asynchronous): head=tail=count=0; all valid/ready bits 0; commitValid, storeCommit, flush = 0; commit data and flushPc = 0.
- Per entry: valid, ready, type, destReg, predTaken, altPc, value.
- Alloc (allocValid=1, no flush this cycle):
  - entry[tail] gets valid=1, ready=0 and the alloc fields.
  - tail wraps from DEPTH-1 to 0.
  - allocValid while count==DEPTH is a protocol violation and is ignored.
  - NOP entries are written with ready=1.
- Update: rsUpdate or lsbUpdate sets value and ready=1 on its index if that entry is valid; updates to invalid entries are ignored.
  - RS and LSB hitting the same index in one cycle is illegal; LSB wins.
  - The two sources on different indices both apply in the same cycle.
- Commit: if entry[head] is valid and ready at a clock edge:
  - drive the commit outputs registered, with commitValid=1 for exactly one cycle;
  - clear entry[head].valid and advance head with wrap.
  - Minimum latency: update at edge N, commit pulse visible after edge N+1.
  - At most one commit per cycle.
- storeCommit=1 alongside commitValid when type=STORE.
- Branch commit: mispredict when (value[0] != predTaken).
  - On mispredict: flush=1 and flushPc=altPc for one cycle, together with commitValid.
  - In the same edge: all valid bits cleared, head=tail=count=0; allocValid and updates in that cycle are discarded.
- Count:
  - count_next = count + alloc_accepted - commit.
  - Simultaneous alloc and commit leave count unchanged.
  - full is derived from the registered count, which gives issue one cycle of slack.
- Query port: queryNReady = valid & ready of the indexed entry; queryNVal = its value (0 if not ready).

Optional Feature:
ROB_BYPASS_EN:
- When defined, the query ports also forward same-cycle broadcasts. If rsUpdate or lsbUpdate targets queryNIndex and that entry is valid, queryNReady=1 and queryNVal = the broadcast value (LSB priority).
- Undefined: query ports read stored state only, so the result becomes visible one cycle after the broadcast.

Test Plan:
1. Reset low mid-run with count=5 -> all outputs 0 immediately; allocRobIndex=0, full=0 after release.
2. Alloc REG x5 at index 0, RS update idx0 val 0x1234 -> next cycle commitValid=1, commitDestReg=5, commitVal=0x1234, head=1.
3. Alloc 15 entries with no updates -> full=1 when count=15. Alloc 1 more -> count=16, allocRobIndex wraps to 0. A further alloc is ignored.
4. Out-of-order completion:
   - alloc idx0,1,2; update idx2 then idx1 -> no commit.
   - Update idx0 -> commits idx0,1,2 on three consecutive cycles.
5. BRANCH predTaken=0, altPc 0x80, then a REG entry; RS update branch val 1 -> flush=1, flushPc=0x80, next cycle count=0 and allocRobIndex=0; REG entry never commits.
6. Query idx3 in the same cycle as lsbUpdate idx3 val 0xAB -> query1Ready=1, query1Val=0xAB with ROB_BYPASS_EN; 0 without, then 1/0xAB the following cycle.
